// File: rtl/pl_3_8_pkg.sv
// Shared widths, default debounce depth and the one-hot LED decode for the 3-to-8 decoder.
package pl_3_8_pkg;

   localparam int unsigned CODE_W           = 3;
   localparam int unsigned LED_W            = 8;
   localparam int unsigned DEFAULT_DEBOUNCE = 4;

   function automatic logic [LED_W-1:0] led_decode(input logic [CODE_W-1:0] code);
      logic [LED_W-1:0] one_hot;
      one_hot       = '0;
      one_hot[code] = 1'b1;
      return one_hot;
   endfunction

endpackage

// File: rtl/pl_3_8_decoder_if.sv
// Switch inputs and LED output of the 3-to-8 decoder, bundled for the top-level port.
interface pl_3_8_decoder_if
   import pl_3_8_pkg::*;
   ;

   logic             SW0;
   logic             SW1;
   logic             SW2;
   logic [LED_W-1:0] LED;

   modport master (output SW0, SW1, SW2, input LED);
   modport slave  (input SW0, SW1, SW2, output LED);

endinterface

// File: rtl/pl_3_8_decoder_sw_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for a WIDTH-bit switch code.
module sw_debounce #(
   parameter int unsigned WIDTH           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable
);

   localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Any change restarts qualification; the counter saturates at CntMax.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q < CntMax) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         acc_d = cand_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q <= '0;
         cnt_q  <= '0;
         acc_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
      end
   end

   assign stable = acc_q;

endmodule

// File: rtl/pl_3_8_decoder.sv
// Debounced 3-bit switch code decoded onto a registered one-hot (optionally inverted) LED bus.
module pl_3_8_decoder
   import pl_3_8_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
   parameter bit          LED_ACTIVE_LOW  = 1'b0
) (
   input logic              clk,
   input logic              rst,
   pl_3_8_decoder_if.slave  bus
);

   localparam logic [LED_W-1:0] LedOff = {LED_W{LED_ACTIVE_LOW}};

   logic [CODE_W-1:0] raw_code;
   logic [CODE_W-1:0] accepted;
   logic [LED_W-1:0]  led_q, led_d;

   assign raw_code = {bus.SW2, bus.SW1, bus.SW0};

   sw_debounce #(
      .WIDTH           (CODE_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_code),
      .stable (accepted)
   );

   // XOR with the inactive level gives the inverted pattern for active-low boards.
   always_comb begin
      led_d = led_decode(accepted) ^ LedOff;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q <= LedOff;
      end else begin
         led_q <= led_d;
      end
   end

   assign bus.LED = led_q;

endmodule

// File: tb/tb_pl_3_8_decoder.sv
// Self-checking bench: active-high and active-low decoders against a sample-window reference model.
module tb_pl_3_8_decoder;

   localparam int unsigned D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] sw  = 3'b000;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pl_3_8_decoder_if bus_hi ();
   pl_3_8_decoder_if bus_lo ();

   assign bus_hi.SW0 = sw[0];
   assign bus_hi.SW1 = sw[1];
   assign bus_hi.SW2 = sw[2];
   assign bus_lo.SW0 = sw[0];
   assign bus_lo.SW1 = sw[1];
   assign bus_lo.SW2 = sw[2];

   pl_3_8_decoder #(
      .DEBOUNCE_CYCLES (D),
      .LED_ACTIVE_LOW  (1'b0)
   ) dut_hi (
      .clk (clk),
      .rst (rst),
      .bus (bus_hi)
   );

   pl_3_8_decoder #(
      .DEBOUNCE_CYCLES (D),
      .LED_ACTIVE_LOW  (1'b1)
   ) dut_lo (
      .clk (clk),
      .rst (rst),
      .bus (bus_lo)
   );

   // Reference: a code is accepted once D+1 consecutive edge samples, ending two edges back
   // (synchronizer delay), all hold it; LED shows the code accepted one edge earlier.
   logic [2:0] hist[$];
   int         acc_m;
   logic [7:0] exp_hi, exp_lo;
   int         m_n;
   logic [2:0] m_c;
   bit         m_eq;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist = {};
         for (int i = 0; i < D + 3; i++) hist.push_back(3'b000);
         acc_m  = 0;
         exp_hi = 8'h00;
         exp_lo = 8'hFF;
      end else begin
         exp_hi = 8'h01 << acc_m;
         exp_lo = ~exp_hi;
         hist.push_back(sw);
         if (hist.size() > 32) void'(hist.pop_front());
         m_n  = hist.size();
         m_c  = hist[m_n-3];
         m_eq = 1'b1;
         for (int i = m_n - 3 - D; i < m_n - 3; i++) if (hist[i] != m_c) m_eq = 1'b0;
         if (m_eq) acc_m = int'(m_c);
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus_hi.LED !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_hi: LED=%h expected=%h", bus_hi.LED, 8'h00);
      end
      n_cmp++;
      if (bus_lo.LED !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_lo: LED=%h expected=%h", bus_lo.LED, 8'hFF);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus_hi.LED !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_held: LED=%h expected=%h", bus_hi.LED, 8'h00);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus_hi.LED !== 8'h01) begin
         n_fail++;
         $display("FAIL reset_release: LED=%h expected=%h", bus_hi.LED, 8'h01);
      end
   endtask

   task automatic test_codes();
      logic [2:0] codes[4];
      logic [7:0] leds[4];
      logic [7:0] prev;
      codes = '{3'b101, 3'b111, 3'b000, 3'b001};
      leds  = '{8'h20, 8'h80, 8'h01, 8'h02};
      prev  = 8'h01;
      for (int i = 0; i < 4; i++) begin
         sw = codes[i];
         for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_hi.LED !== exp_hi) begin
               n_fail++;
               $display("FAIL codes_model: code=%b edge=%0d LED=%h expected=%h",
                        codes[i], e, bus_hi.LED, exp_hi);
            end
            if (e == 7) begin
               n_cmp++;
               if (bus_hi.LED !== prev) begin
                  n_fail++;
                  $display("FAIL codes_early: code=%b LED=%h expected=%h", codes[i], bus_hi.LED,
                           prev);
               end
            end
            if (e == 8) begin
               n_cmp++;
               if (bus_hi.LED !== leds[i]) begin
                  n_fail++;
                  $display("FAIL codes_latency: code=%b LED=%h expected=%h", codes[i],
                           bus_hi.LED, leds[i]);
               end
            end
         end
         prev = leds[i];
      end
   endtask

   task automatic test_glitch();
      sw = 3'b000;
      repeat (12) @(negedge clk);
      sw = 3'b010;
      repeat (2) @(negedge clk);
      sw = 3'b000;
      for (int e = 0; e < 14; e++) begin
         @(negedge clk);
         n_cmp++;
         if (bus_hi.LED !== 8'h01 || bus_hi.LED !== exp_hi) begin
            n_fail++;
            $display("FAIL glitch: cycle=%0d LED=%h expected=%h model=%h", e, bus_hi.LED, 8'h01,
                     exp_hi);
         end
      end
   endtask

   task automatic test_reset_mid();
      sw = 3'b110;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus_hi.LED !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_async: LED=%h expected=%h", bus_hi.LED, 8'h00);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         n_cmp++;
         if (bus_hi.LED !== exp_hi) begin
            n_fail++;
            $display("FAIL midreset_model: edge=%0d LED=%h expected=%h", e, bus_hi.LED, exp_hi);
         end
         if (e == 1 || e == 7) begin
            n_cmp++;
            if (bus_hi.LED !== 8'h01) begin
               n_fail++;
               $display("FAIL midreset_pending: edge=%0d LED=%h expected=%h", e, bus_hi.LED,
                        8'h01);
            end
         end
         if (e == 8) begin
            n_cmp++;
            if (bus_hi.LED !== 8'h40) begin
               n_fail++;
               $display("FAIL midreset_requal: LED=%h expected=%h", bus_hi.LED, 8'h40);
            end
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0] want;
      int         hold;
      for (int c = 0; c < 8; c++) begin
         sw   = 3'(c);
         want = 8'h01 << c;
         for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_cmp++;
            if (!$onehot(bus_hi.LED) || bus_hi.LED !== exp_hi || bus_lo.LED !== exp_lo) begin
               n_fail++;
               $display("FAIL sweep_model: code=%0d edge=%0d LED=%h/%h expected=%h/%h", c, e,
                        bus_hi.LED, bus_lo.LED, exp_hi, exp_lo);
            end
            if (e == 8) begin
               n_cmp++;
               if (bus_hi.LED !== want) begin
                  n_fail++;
                  $display("FAIL sweep_index: code=%0d LED=%h expected=%h", c, bus_hi.LED, want);
               end
            end
         end
      end
      for (int s = 0; s < 60; s++) begin
         sw   = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 10);
         for (int e = 0; e < hold; e++) begin
            @(negedge clk);
            n_cmp++;
            if (!$onehot(bus_hi.LED) || bus_hi.LED !== exp_hi || bus_lo.LED !== exp_lo) begin
               n_fail++;
               $display("FAIL random_model: step=%0d sw=%b LED=%h/%h expected=%h/%h", s, sw,
                        bus_hi.LED, bus_lo.LED, exp_hi, exp_lo);
            end
         end
      end
   endtask

   task automatic test_active_low();
      sw = 3'b011;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         n_cmp++;
         if (bus_lo.LED !== exp_lo) begin
            n_fail++;
            $display("FAIL active_low_model: edge=%0d LED=%h expected=%h", e, bus_lo.LED, exp_lo);
         end
      end
      n_cmp++;
      if (bus_lo.LED !== 8'hF7) begin
         n_fail++;
         $display("FAIL active_low_011: LED=%h expected=%h", bus_lo.LED, 8'hF7);
      end
   endtask

   initial begin
      test_reset();
      test_codes();
      test_glitch();
      test_reset_mid();
      test_sweep();
      test_active_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
